icache_line_fetcher: RTL

//  Refill engine directly downstream of the instruction cache miss path. Takes one line-address request
//  (pulse + line address, no byte offset), issues one burst read on a narrower memory bus, packs the

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_beat_packer.sv | 47 ++++
 rtl/icache_line_fetcher.sv | 130 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, helpers and FSM state type for the I-cache line fetcher.
package icache_pkg;

    // Default geometry: 32 words of 32 bits per line, refilled over a 64-bit bus.
    localparam int ICACHE_ADDR_WIDTH = 32;
    localparam int ICACHE_DATA_WIDTH = 32;
    localparam int ICACHE_BLOCK_SIZE = 32;
    localparam int ICACHE_MEM_WIDTH  = 64;

    localparam int ICACHE_LINE_BITS  = ICACHE_BLOCK_SIZE * ICACHE_DATA_WIDTH;
    localparam int ICACHE_OFFSET_W   = $clog2(ICACHE_LINE_BITS / 8);
    localparam int ICACHE_BEATS      = ICACHE_LINE_BITS / ICACHE_MEM_WIDTH;

    // Refill sequencing: wait for a miss, issue the burst, collect beats, hand the line back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    // Counter width that stays at least one bit even for single-beat lines.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_beat_packer.sv
// icache_beat_packer: counts incoming memory beats and drops each one into its
// slot of the line register, lowest beat at the lowest bit position.
module icache_beat_packer
    import icache_pkg::*;
#(
    parameter int MEM_WIDTH = ICACHE_MEM_WIDTH,
    parameter int BEATS     = ICACHE_BEATS
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_clear,
    input  logic                         i_beat_valid,
    input  logic [MEM_WIDTH-1:0]         i_beat_data,
    output logic                         o_last_beat,
    output logic [BEATS*MEM_WIDTH-1:0]   o_line
);

    localparam int CNT_W = cnt_width(BEATS);

    logic [CNT_W-1:0]           r_cnt;
    logic [BEATS*MEM_WIDTH-1:0] r_line;
    logic                       w_at_last;

    assign w_at_last   = (r_cnt == CNT_W'(BEATS - 1));
    assign o_last_beat = i_beat_valid & w_at_last;
    assign o_line      = r_line;

    // Beat index: restarts at each new burst, parks at 0 after the final beat.
    always_ff @(posedge CLK) begin
        if (RST)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_beat_valid)
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end

    // Line assembly: only the addressed slot changes, so a finished line
    // stays put until the next burst starts overwriting it.
    always_ff @(posedge CLK) begin
        if (RST)
            r_line <= '0;
        else if (i_beat_valid)
            r_line[int'(r_cnt) * MEM_WIDTH +: MEM_WIDTH] <= i_beat_data;
    end

endmodule

// File: rtl/icache_line_fetcher.sv
// icache_line_fetcher: refill engine behind the I-cache miss path. One line
// request in, one burst read out, beats packed into a line, 1-cycle LINE_VALID.
// Optional feature macro: ICACHE_LINE_BUF_HIT_EN (one-entry last-line buffer
// that answers a repeat request without touching memory).
module icache_line_fetcher
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
    parameter int BLOCK_SIZE = ICACHE_BLOCK_SIZE,
    parameter int MEM_WIDTH  = ICACHE_MEM_WIDTH,
    parameter int LINE_BITS  = BLOCK_SIZE * DATA_WIDTH,
    parameter int OFFSET_W   = $clog2(LINE_BITS / 8),
    parameter int BEATS      = LINE_BITS / MEM_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         FLUSH,
    input  logic                         REQ_VALID,
    input  logic [ADDR_WIDTH-OFFSET_W-1:0] REQ_ADDR,
    output logic                         LINE_VALID,
    output logic [LINE_BITS-1:0]         LINE_DATA,
    output logic                         BUSY,
    output logic                         MEM_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
    input  logic                         MEM_ADDR_READY,
    input  logic                         MEM_RDATA_VALID,
    input  logic [MEM_WIDTH-1:0]         MEM_RDATA
);

    localparam int LA_W = ADDR_WIDTH - OFFSET_W;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [LA_W-1:0] r_addr;
    logic            w_start;
    logic            w_accept;
    logic            w_beat;
    logic            w_last_beat;
    logic            w_hit;

    // A request only counts in IDLE; anything arriving while busy is dropped.
    assign w_start  = (r_state == IDLE) && REQ_VALID;
    assign w_accept = (r_state == REQ)  && MEM_ADDR_READY;
    // Beats outside DATA (e.g. stragglers from before a reset) never reach the packer.
    assign w_beat   = (r_state == DATA) && MEM_RDATA_VALID;

`ifdef ICACHE_LINE_BUF_HIT_EN
    logic            r_buf_valid;
    logic [LA_W-1:0] r_buf_tag;
    logic            r_hit;

    // A FLUSH arriving with the request wins: the caller wants fresh data.
    assign w_hit = r_buf_valid && !FLUSH && (REQ_ADDR == r_buf_tag);

    // Remember whether the current delivery came from the buffer or from memory.
    always_ff @(posedge CLK) begin
        if (RST)
            r_hit <= 1'b0;
        else if (r_state == IDLE)
            r_hit <= REQ_VALID && w_hit;
    end

    // Line buffer: becomes valid once a fetched line is delivered; FLUSH
    // clears it at any time, including during the delivery cycle itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
        end else if (FLUSH) begin
            r_buf_valid <= 1'b0;
        end else if ((r_state == DONE) && !r_hit) begin
            r_buf_valid <= 1'b1;
            r_buf_tag   <= r_addr;
        end
    end
`else
    logic w_unused_flush;

    assign w_hit          = 1'b0;
    assign w_unused_flush = FLUSH;
`endif

    icache_beat_packer #(
        .MEM_WIDTH (MEM_WIDTH),
        .BEATS     (BEATS)
    ) u_packer (
        .CLK          (CLK),
        .RST          (RST),
        .i_clear      (w_accept),
        .i_beat_valid (w_beat),
        .i_beat_data  (MEM_RDATA),
        .o_last_beat  (w_last_beat),
        .o_line       (LINE_DATA)
    );

    // Next-state logic for the refill sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)     w_state_nxt = w_hit ? DONE : REQ;
            REQ:     if (w_accept)    w_state_nxt = DATA;
            DATA:    if (w_last_beat) w_state_nxt = DONE;
            DONE:                     w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any partial line.
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Line address of the fetch in flight, held steady through the handshake.
    always_ff @(posedge CLK) begin
        if (RST)
            r_addr <= '0;
        else if (w_start && !w_hit)
            r_addr <= REQ_ADDR;
    end

    assign MEM_ADDR_VALID = (r_state == REQ);
    assign MEM_ADDR       = {r_addr, {OFFSET_W{1'b0}}};
    assign LINE_VALID     = (r_state == DONE);
    assign BUSY           = (r_state != IDLE);

endmodule
